pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameters: RW, 4, register-address width; CW, 16, width of each performance counter; DRAIN, 3, unfrozen cycles from HLT acceptance to hlt assertion.
REQ-002 SHALL use one clock and a synchronous, active-low reset: clk  input  1  system clock, all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 D_src1, D_src2  input  RW each  decode-stage source register addresses; D_use1, D_use2  input  1 each  source actually read.
REQ-005 D_branch  input  1  decode holds register-indirect branch reading D_src1; D_hlt  input  1  decode holds HLT.
REQ-006 X_src1, X_src2, X_dst  input  RW each; X_regwrite, X_memread  input  1 each  execute-stage fields.
REQ-007 M_dst  input  RW; M_regwrite, M_memread  input  1 each; W_dst  input  RW; W_regwrite  input  1.
REQ-008 br_taken  input  1  decode branch resolved taken; imem_stall, dmem_stall  input  1 each  memory not ready.
REQ-009 pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen  output  1 each  pipeline-register write enables.
REQ-010 ifid_flush, idex_bubble  output  1 each  insert NOP into IF/ID, control-zero into ID/EX.
REQ-011 fwd_a, fwd_b  output  2 each  execute operand select: 00 regfile, 01 MEM/WB, 10 EX/MEM.
REQ-012 hlt  output  1; stall_cnt, flush_cnt  output  CW each.

Function
REQ-013 Register 0 SHALL never be a hazard or forwarding source (address 0 matches nothing).
REQ-014 Load-use hazard SHALL be: X_memread & X_regwrite & X_dst matches a used D source.
REQ-015 Branch hazard SHALL be: D_branch & ((X_regwrite & X_dst==D_src1) | (M_memread & M_dst==D_src1)); a load in X gives 2 stall cycles, an ALU op in X gives 1.
REQ-016 Priority SHALL be: dmem_stall > halt state > hazard stall > branch flush > imem_stall.
REQ-017 dmem_stall SHALL drive all five wen low, ifid_flush=0, idex_bubble=0 (full freeze).
REQ-018 Hazard stall SHALL drive pc_wen=0, ifid_wen=0, idex_bubble=1, other wen=1.
REQ-019 br_taken without stall SHALL drive ifid_flush=1; br_taken during stall SHALL be ignored that cycle.
REQ-020 imem_stall alone SHALL drive pc_wen=0, ifid_flush=1.
REQ-021 fwd_a SHALL be 10 when M_regwrite & ~M_memread & M_dst==X_src1, else 01 when W_regwrite & W_dst==X_src1, else 00; fwd_b identical on X_src2; EX/MEM wins over MEM/WB.
REQ-022 FSM states RUN, DRAIN, HALTED; RUN->DRAIN when D_hlt and no dmem_stall/hazard stall, counter loaded with DRAIN.
REQ-023 In DRAIN/HALTED: pc_wen=0, ifid_flush=1, idex_bubble=1; counter decrements only on cycles without dmem_stall.
REQ-024 DRAIN->HALTED when counter reaches 0; hlt registered, high from first HALTED cycle, sticky until reset.
REQ-025 D_hlt during hazard stall SHALL not be accepted until the stall clears.
REQ-026 stall_cnt SHALL increment on each hazard-stall cycle, flush_cnt on each asserted ifid_flush caused by br_taken; both saturate at all-ones.
REQ-027 All outputs except hlt and counters SHALL be combinational from inputs and state.

Reset
REQ-028 On rst_n=0 at clk edge: state RUN, drain counter 0, hlt=0, stall_cnt=0, flush_cnt=0.
REQ-029 Reset mid-DRAIN or in HALTED SHALL return to RUN next cycle with no residual stall.
REQ-030 While rst_n=0, all wen outputs SHALL be 1, flush/bubble 0, fwd 00.

Structure
REQ-031 Shared package hazard_pkg SHALL hold fwd select encodings, FSM state enum, RW/CW defaults.
REQ-032 One sub-module sat_counter (width CW, inc, synchronous clear) SHALL be instantiated twice.

Verification
REQ-033 LW R3 in X, ADD reading R3 in D -> one cycle pc_wen=0, idex_bubble=1, stall_cnt 0->1.
REQ-034 ADD R5 in M, SUB reading R5,R5 in X, ADD R5 in W -> fwd_a=fwd_b=10.
REQ-035 LW R2 in X, BR reading R2 in D -> two stall cycles, then br_taken -> ifid_flush=1, flush_cnt=1.
REQ-036 D_hlt with DRAIN=3, dmem_stall high 1 cycle in DRAIN -> hlt rises 4 cycles after acceptance, stays high.
REQ-037 dmem_stall with simultaneous load-use and br_taken -> all wen=0, no bubble, no counter change.
REQ-038 Hazard on R0 (X_dst=0, memread) -> no stall, fwd 00; counter at 0xFFFF stall -> stays 0xFFFF.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared definitions for the pipeline hazard controller.
//                Holds the default address and counter widths, the operand
//                forwarding select encodings, the control FSM state type and
//                a small helper that resolves a forwarding select.
//  Revision    : 1.0  initial release
// ============================================================================
package hazard_pkg;

    localparam int RW_DEFAULT = 4;
    localparam int CW_DEFAULT = 16;

    // Execute-stage operand source selects
    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_MEMWB   = 2'b01;
    localparam logic [1:0] FWD_EXMEM   = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } hz_state_t;

    // The younger producer in EX/MEM always wins over MEM/WB.
    function automatic logic [1:0] fwd_sel(input logic exmem_hit, input logic memwb_hit);
        if (exmem_hit) begin
            return FWD_EXMEM;
        end else if (memwb_hit) begin
            return FWD_MEMWB;
        end
        return FWD_REGFILE;
    endfunction

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl_if
//  Description : Bundle of pipeline-stage fields observed by the hazard
//                controller and the control outputs it returns.
//                slave  : the hazard controller (stage fields in, controls out)
//                master : the pipeline datapath (stage fields out, controls in)
//  Ports       : D_*  decode-stage sources / branch / halt
//                X_*  execute-stage sources, destination, write/load flags
//                M_*, W_*  memory and write-back stage destinations
//                br_taken, imem_stall, dmem_stall  event inputs
//                *_wen, ifid_flush, idex_bubble, fwd_a/b  pipeline controls
//                hlt, stall_cnt, flush_cnt  status and performance counters
//  Revision    : 1.0  initial release
// ============================================================================
interface pipe_hazard_ctrl_if #(
    parameter int RW = hazard_pkg::RW_DEFAULT,
    parameter int CW = hazard_pkg::CW_DEFAULT
);
    // Decode stage
    logic [RW-1:0] D_src1;
    logic [RW-1:0] D_src2;
    logic          D_use1;
    logic          D_use2;
    logic          D_branch;
    logic          D_hlt;
    // Execute stage
    logic [RW-1:0] X_src1;
    logic [RW-1:0] X_src2;
    logic [RW-1:0] X_dst;
    logic          X_regwrite;
    logic          X_memread;
    // Memory / write-back stages
    logic [RW-1:0] M_dst;
    logic          M_regwrite;
    logic          M_memread;
    logic [RW-1:0] W_dst;
    logic          W_regwrite;
    // Events
    logic          br_taken;
    logic          imem_stall;
    logic          dmem_stall;
    // Controls
    logic          pc_wen;
    logic          ifid_wen;
    logic          idex_wen;
    logic          exmem_wen;
    logic          memwb_wen;
    logic          ifid_flush;
    logic          idex_bubble;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;
    // Status
    logic          hlt;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;

    modport slave (
        input  D_src1, D_src2, D_use1, D_use2, D_branch, D_hlt,
        input  X_src1, X_src2, X_dst, X_regwrite, X_memread,
        input  M_dst, M_regwrite, M_memread, W_dst, W_regwrite,
        input  br_taken, imem_stall, dmem_stall,
        output pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen,
        output ifid_flush, idex_bubble, fwd_a, fwd_b,
        output hlt, stall_cnt, flush_cnt
    );

    modport master (
        output D_src1, D_src2, D_use1, D_use2, D_branch, D_hlt,
        output X_src1, X_src2, X_dst, X_regwrite, X_memread,
        output M_dst, M_regwrite, M_memread, W_dst, W_regwrite,
        output br_taken, imem_stall, dmem_stall,
        input  pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen,
        input  ifid_flush, idex_bubble, fwd_a, fwd_b,
        input  hlt, stall_cnt, flush_cnt
    );

endinterface : pipe_hazard_ctrl_if
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at all-ones instead of wrapping.
//  Ports       : clk    system clock
//                clr    synchronous clear, wins over inc
//                inc    count enable for this cycle
//                count  current value
//  Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  wire logic         clk,
    input  wire logic         clr,
    input  wire logic         inc,
    output logic      [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Hazard and control unit for a five-stage in-order pipeline.
//                Detects load-use and register-indirect branch hazards,
//                selects execute operand forwarding, applies memory stalls
//                and branch flushes, and sequences an orderly halt that
//                drains DRAIN unfrozen cycles before raising hlt.
//                Priority: dmem_stall > halt state > hazard stall >
//                branch flush > imem_stall.
//  Ports       : clk    system clock
//                rst_n  synchronous active-low reset
//                bus    stage fields in, pipeline controls and status out
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int RW    = RW_DEFAULT,
    parameter int CW    = CW_DEFAULT,
    parameter int DRAIN = 3
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int             DCW        = (DRAIN < 2) ? 1 : $clog2(DRAIN + 1);
    localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN);

    // Address 0 is hard-wired zero, so it never produces a dependency.
    function automatic logic reg_hit(input logic [RW-1:0] a, input logic [RW-1:0] b);
        return (a != '0) && (a == b);
    endfunction

    hz_state_t      state_q;
    hz_state_t      state_d;
    logic [DCW-1:0] drain_cnt_q;
    logic [DCW-1:0] drain_cnt_d;
    logic           hlt_q;
    logic           hlt_d;

    logic           load_use;
    logic           br_hazard;
    logic           hazard_stall;

    logic           pc_wen;
    logic           ifid_wen;
    logic           idex_wen;
    logic           exmem_wen;
    logic           memwb_wen;
    logic           ifid_flush;
    logic           idex_bubble;
    logic [1:0]     fwd_a;
    logic [1:0]     fwd_b;
    logic           stall_inc;
    logic           flush_inc;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    // A branch in decode compares its register immediately, so an ALU
    // result still in X costs one cycle and a load costs two (once in X,
    // once more in M while the data is still coming back from memory).
    always_comb begin
        load_use = bus.X_memread && bus.X_regwrite &&
                   ((bus.D_use1 && reg_hit(bus.X_dst, bus.D_src1)) ||
                    (bus.D_use2 && reg_hit(bus.X_dst, bus.D_src2)));
        br_hazard = bus.D_branch &&
                    ((bus.X_regwrite && reg_hit(bus.X_dst, bus.D_src1)) ||
                     (bus.M_memread  && reg_hit(bus.M_dst, bus.D_src1)));
        hazard_stall = load_use || br_hazard;
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= '0;
            hlt_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            hlt_q       <= hlt_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        hlt_d       = hlt_q;
        case (state_q)
            ST_RUN: begin
                // HLT waits in decode until nothing ahead of it is stalled.
                if (bus.D_hlt && !bus.dmem_stall && !hazard_stall) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                // Frozen cycles do not advance the pipeline, so they do not
                // count toward the drain. Leaving on the last count makes hlt
                // visible exactly DRAIN unfrozen cycles after acceptance.
                if (!bus.dmem_stall) begin
                    if (drain_cnt_q <= DCW'(1)) begin
                        state_d     = ST_HALTED;
                        drain_cnt_d = '0;
                        hlt_d       = 1'b1;
                    end else begin
                        drain_cnt_d = drain_cnt_q - DCW'(1);
                    end
                end
            end
            ST_HALTED: begin
                hlt_d = 1'b1;
            end
            default: begin
                state_d     = ST_RUN;
                drain_cnt_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (pipeline controls, counter events)
    // ------------------------------------------------------------------
    always_comb begin
        pc_wen      = 1'b1;
        ifid_wen    = 1'b1;
        idex_wen    = 1'b1;
        exmem_wen   = 1'b1;
        memwb_wen   = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        if (!rst_n) begin
            // Pass-through controls while held in reset.
        end else if (bus.dmem_stall) begin
            pc_wen    = 1'b0;
            ifid_wen  = 1'b0;
            idex_wen  = 1'b0;
            exmem_wen = 1'b0;
            memwb_wen = 1'b0;
        end else if (state_q != ST_RUN) begin
            // Keep feeding NOPs so the older instructions drain out.
            pc_wen      = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (hazard_stall) begin
            pc_wen      = 1'b0;
            ifid_wen    = 1'b0;
            idex_bubble = 1'b1;
            stall_inc   = 1'b1;
        end else if (bus.br_taken) begin
            ifid_flush = 1'b1;
            flush_inc  = 1'b1;
        end else if (bus.imem_stall) begin
            pc_wen     = 1'b0;
            ifid_flush = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Operand forwarding (a load in MEM has no data yet, so it is skipped)
    // ------------------------------------------------------------------
    always_comb begin
        fwd_a = FWD_REGFILE;
        fwd_b = FWD_REGFILE;
        if (rst_n) begin
            fwd_a = fwd_sel(bus.M_regwrite && !bus.M_memread && reg_hit(bus.M_dst, bus.X_src1),
                            bus.W_regwrite && reg_hit(bus.W_dst, bus.X_src1));
            fwd_b = fwd_sel(bus.M_regwrite && !bus.M_memread && reg_hit(bus.M_dst, bus.X_src2),
                            bus.W_regwrite && reg_hit(bus.W_dst, bus.X_src2));
        end
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    sat_counter #(.W(CW)) u_stall_cnt (
        .clk   (clk),
        .clr   (!rst_n),
        .inc   (stall_inc),
        .count (bus.stall_cnt)
    );

    sat_counter #(.W(CW)) u_flush_cnt (
        .clk   (clk),
        .clr   (!rst_n),
        .inc   (flush_inc),
        .count (bus.flush_cnt)
    );

    assign bus.pc_wen      = pc_wen;
    assign bus.ifid_wen    = ifid_wen;
    assign bus.idex_wen    = idex_wen;
    assign bus.exmem_wen   = exmem_wen;
    assign bus.memwb_wen   = memwb_wen;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_bubble = idex_bubble;
    assign bus.fwd_a       = fwd_a;
    assign bus.fwd_b       = fwd_b;
    assign bus.hlt         = hlt_q;

endmodule : pipe_hazard_ctrl
`default_nettype wire
